// File: rtl/modexp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// modexp_ctrl_pkg
// Shared definitions for the modular-exponentiation sequencer:
//   - state_t   : 3-bit encoding of the six sequencer states
//   - op_count  : number of multiplier operations one exponentiation issues,
//                 as a function of the exponent and the constant-time mode
// -----------------------------------------------------------------------------
package modexp_ctrl_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE      = 3'd0,
    S_SQ_ISSUE  = 3'd1,
    S_SQ_WAIT   = 3'd2,
    S_MUL_ISSUE = 3'd3,
    S_MUL_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // One squaring per exponent bit, plus one multiply per set bit
  // (or per bit unconditionally in constant-time mode).
  function automatic int op_count(input logic [31:0] e, input int ew, input bit ct);
    int n;
    n = ew;
    for (int i = 0; i < ew; i++) begin
      if (ct || e[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// -----------------------------------------------------------------------------
// modexp_ctrl
// Left-to-right square-and-multiply sequencer computing base^exp mod N.
// Contains no arithmetic: every square/multiply is handed to an external
// modular multiplier (which holds N) over a start/done handshake.
//
// Parameters
//   WIDTH      : operand / result width
//   EXP_WIDTH  : exponent width, = number of loop iterations (>=1)
//   CONST_TIME : 1 = multiply issued for every bit (dummy on 0 bits)
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, base, exp     : request and operands, accepted only when idle
//   busy                 : high whenever not idle
//   done, result         : one-cycle completion pulse; result held until the
//                          next accepted start
//   mm_start, mm_a, mm_b : issue pulse and operands to the multiplier
//   mm_done, mm_res      : multiplier completion strobe and product
// -----------------------------------------------------------------------------
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EXP_WIDTH  = 8,
  parameter int CONST_TIME = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  input  logic                 mm_done,
  input  logic [WIDTH-1:0]     mm_res
);

  localparam int   IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic CT_MODE = (CONST_TIME != 0);

  state_t               r_state, w_state_next;
  logic [WIDTH-1:0]     r_acc, w_acc_next;
  logic [WIDTH-1:0]     r_base;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic [WIDTH-1:0]     r_result, w_result_next;
  logic                 w_capture;
  logic                 w_bit;
  logic                 w_last;

  assign w_bit  = r_exp[r_idx];
  assign w_last = (r_idx == '0);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_base   <= '0;
      r_exp    <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_idx    <= w_idx_next;
      r_result <= w_result_next;
      if (w_capture) begin
        r_base <= base;
        r_exp  <= exp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_idx_next    = r_idx;
    w_result_next = r_result;
    w_capture     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_acc_next   = WIDTH'(1);
          w_idx_next   = IDX_W'(EXP_WIDTH - 1);
          w_state_next = S_SQ_ISSUE;
        end
      end

      S_SQ_ISSUE: w_state_next = S_SQ_WAIT;

      S_SQ_WAIT: begin
        if (mm_done) begin
          w_acc_next = mm_res;
          if (w_bit || CT_MODE) begin
            w_state_next = S_MUL_ISSUE;
          end else if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx - 1'b1;
            w_state_next = S_SQ_ISSUE;
          end
        end
      end

      S_MUL_ISSUE: w_state_next = S_MUL_WAIT;

      S_MUL_WAIT: begin
        if (mm_done) begin
          // A multiply on a zero bit is a dummy: its product is dropped.
          if (w_bit) w_acc_next = mm_res;
          if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx - 1'b1;
            w_state_next = S_SQ_ISSUE;
          end
        end
      end

      S_DONE: w_state_next = S_IDLE;

      default: w_state_next = S_IDLE;
    endcase

    // Latch the final accumulator on entry to DONE so result is already
    // valid in the cycle done is high.
    if (w_state_next == S_DONE && r_state != S_DONE) begin
      w_result_next = w_acc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all registered or decoded from the state register
  // ---------------------------------------------------------------------------
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign mm_start = (r_state == S_SQ_ISSUE) || (r_state == S_MUL_ISSUE);
  assign mm_a     = r_acc;
  // r_acc only changes on the mm_done edge, so both operands stay stable
  // while the multiplier is working.
  assign mm_b     = ((r_state == S_MUL_ISSUE) || (r_state == S_MUL_WAIT)) ? r_base : r_acc;

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
Sequencer for modular exponentiation (result = base^exp mod N) using left-to-right square-and-multiply. It owns no arithmetic. Each square or multiply is issued to an external modular multiplier over a start/done handshake; N is configured in that multiplier. The block sits between the RSA top-level and the shared multiplier. A CONST_TIME mode issues a dummy multiply for zero exponent bits so the operation count is independent of exp.

Parameters:
WIDTH, 8, data width of base, result and multiplier operands
EXP_WIDTH, 8, exponent width (>=1); number of loop iterations
CONST_TIME, 1, 1 = always issue multiply (dummy when bit=0); 0 = multiply only on exp bit=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
base  in  WIDTH  base operand, captured on accepted start
exp  in  EXP_WIDTH  exponent, captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; result valid
result  out  WIDTH  final accumulator; held until next accepted start
mm_start  out  1  one-cycle issue pulse to multiplier
mm_a  out  WIDTH  multiplier operand A (accumulator)
mm_b  out  WIDTH  multiplier operand B (accumulator for square, base for multiply)
mm_done  in  1  multiplier completion strobe
mm_res  in  WIDTH  multiplier result (a*b mod N), valid when mm_done=1

Behaviour:
- Reset: IDLE. busy=0, done=0, result=0, mm_start=0, mm_a=0, mm_b=0. Bit index, accumulator, captured base and exp are all cleared.
- Reset mid-operation aborts immediately. No done pulse is produced. The multiplier shares rst_n.
- States: IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
- IDLE with start=1:
  - capture base and exp; acc=1; bit index i=EXP_WIDTH-1; go to SQ_ISSUE.
  - start in any other state is ignored; no queuing.
- SQ_ISSUE: mm_start=1, mm_a=acc, mm_b=acc; go to SQ_WAIT.
- SQ_WAIT: hold mm_a/mm_b stable. On mm_done:
  - acc=mm_res.
  - If exp[i]=1 or CONST_TIME=1, go to MUL_ISSUE.
  - Otherwise, if i==0 go to DONE; else i=i-1 and go to SQ_ISSUE.
- MUL_ISSUE: mm_start=1, mm_a=acc, mm_b=base; go to MUL_WAIT.
- MUL_WAIT: on mm_done:
  - if exp[i]=1, acc=mm_res; else discard mm_res (dummy multiply).
  - If i==0 go to DONE; else i=i-1 and go to SQ_ISSUE.
- DONE: done=1, result=acc; go to IDLE next cycle.
- mm_done outside SQ_WAIT/MUL_WAIT is ignored. There is no timeout.
- mm_start is high only in ISSUE states, never on two consecutive cycles.
- Operation count:
  - CONST_TIME=1: 2*EXP_WIDTH, regardless of exp.
  - CONST_TIME=0: EXP_WIDTH + popcount(exp).
- Latency: multiplier latency L = cycles from the mm_start cycle to the mm_done cycle (L>=1). Each operation costs L+1 cycles. With start accepted in cycle 0, done is high in cycle ops*(L+1)+1.
- exp=0 gives result = 1 mod N, produced by the squarings; the cycle count still follows the operation-count rule above.
- All outputs are register-driven or decoded from the state register. mm_b's multiplexer selects only between two registers.

Decomposition:
- Shared package:
  - state encoding constants (6 states, 3-bit);
  - an op-count function op_count(exp, CONST_TIME), used by the bench.
- Single module; no sub-module is warranted. The multiplier is instantiated beside this block in the parent, not inside it.
- The bench uses a behavioural mod-N multiplier with programmable L.

Test Plan (bench multiplier: N=13, L=8, WIDTH=EXP_WIDTH=8):
1. CONST_TIME=1, base=3, exp=0x05 -> result=9; done in cycle 145; exactly 16 mm_start pulses, 8 with mm_b=3.
2. CONST_TIME=0, base=3, exp=0x05 -> result=9; done in cycle 91; 10 mm_start pulses.
3. CONST_TIME=1, exp=0x01 vs exp=0xFF, base=2 -> results 2 and 8; both done in cycle 145 (timing independent of exp).
4. exp=0x00, base=7, either mode -> result=1.
   - CONST_TIME=1: done in cycle 145.
   - CONST_TIME=0: done in cycle 73.
5. start pulsed in cycle 20 of a run, and a spurious mm_done injected during SQ_ISSUE -> both ignored; result and done cycle unchanged.
6. rst_n low in cycle 50 of a run -> all outputs 0, state IDLE, no done pulse; a new start afterwards completes correctly (base=3, exp=0x05 -> 9).
